// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Responder side of the pipeline's data-memory interface. It accepts one
// single-word load or store from the MEM stage over a valid/ready handshake.
// It then waits a fixed number of cycles, performs the access on a
// word-addressed array, and returns the result over a second valid/ready
// handshake. Only one request is ever in flight. busy_o is high from accept
// until the response is consumed, and it drives the MEM-stage stall.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of two, >= 2)
//   LATENCY     : cycles from request accept to response valid (1..15)
//
// Ports
//   clk_i        in   clock, all state updates on the rising edge
//   rst_i        in   synchronous active-high reset (array is not cleared)
//   req_valid_i  in   CPU presents a request
//   req_ready_o  out  responder can accept a request this cycle (IDLE)
//   req_write_i  in   1 = store, 0 = load
//   req_addr_i   in   byte address [31:0]
//   req_wdata_i  in   store data [31:0]
//   resp_valid_o out  response available
//   resp_ready_i in   CPU consumes the response
//   resp_rdata_o out  load data [31:0] (0 for stores and errors)
//   resp_err_o   out  request was misaligned or out of range
//   busy_o       out  request outstanding (accepted, response not consumed)
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Control state (reset)
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        busy_q, busy_d;

  // Latched request (data path, no reset needed)
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             commit;

  always_comb begin
    idx      = addr_q[IDX_W+1:2];
    // Misaligned, or any bit above the word-index field set.
    addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (IDX_W + 2)) != 32'd0);

    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    busy_d       = busy_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          write_d     = req_write_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          cnt_d       = 4'(LATENCY - 1);
          state_d     = S_WAIT;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Access happens on this edge; the response registers load with it.
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          if (addr_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (write_q) begin
            commit       = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'd0;
          end else begin
            resp_err_d   = 1'b0;
            resp_rdata_d = mem[idx];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          // Back to IDLE; a new request is taken on the following edge at the earliest.
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          busy_d       = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // A store landing on a reset edge is dropped along with its request.
  always_ff @(posedge clk_i) begin
    if (commit && !rst_i) begin
      mem[idx] <= wdata_q;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//
// Two instances: dut_a with LATENCY=4 and dut_b with LATENCY=1, both with
// 256 words. Directed requests push their expected response, including the
// cycle at which it must first appear, into a per-DUT queue. A monitor per
// DUT compares every presented response cycle against the queue head and
// pops on handshake. Inputs change 2 ns after the rising edge, and the
// monitors sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          first_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, req_valid_a, req_ready_a, req_write_a;
  logic [31:0] req_addr_a, req_wdata_a, rdata_a;
  logic        resp_valid_a, resp_ready_a, err_a, busy_a;

  logic        rst_b, req_valid_b, req_ready_b, req_write_b;
  logic [31:0] req_addr_b, req_wdata_b, rdata_b;
  logic        resp_valid_b, resp_ready_b, err_b, busy_b;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_write_i(req_write_a), .req_addr_i(req_addr_a), .req_wdata_i(req_wdata_a),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready_a),
    .resp_rdata_o(rdata_a), .resp_err_o(err_a), .busy_o(busy_a)
  );

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_write_i(req_write_b), .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready_b),
    .resp_rdata_o(rdata_b), .resp_err_o(err_b), .busy_o(busy_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: check every response cycle against the queue head, pop on handshake.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_resp", {31'd0, resp_valid_a}, 32'd0);
        end else begin
          if (!seen) begin
            chk("a_latency", 32'(cyc), 32'(q_a[0].first_cyc));
            seen = 1'b1;
          end
          chk("a_rdata", rdata_a, q_a[0].rdata);
          chk("a_err", {31'd0, err_a}, {31'd0, q_a[0].err});
          chk("a_busy_resp", {31'd0, busy_a}, 32'd1);
          if (resp_ready_a) begin
            void'(q_a.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_resp", {31'd0, resp_valid_b}, 32'd0);
        end else begin
          if (!seen) begin
            chk("b_latency", 32'(cyc), 32'(q_b[0].first_cyc));
            seen = 1'b1;
          end
          chk("b_rdata", rdata_b, q_b[0].rdata);
          chk("b_err", {31'd0, err_b}, {31'd0, q_b[0].err});
          if (resp_ready_b) begin
            void'(q_b.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present a request (call 2 ns after a rising edge); returns the accept edge.
  task automatic issue(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err, input bit want_resp, output int acc);
    int   t = 0;
    logic rdy;
    exp_t e;
    if (!sel) begin
      req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wdata;
    end else begin
      req_valid_b = 1'b1; req_write_b = wr; req_addr_b = addr; req_wdata_b = wdata;
    end
    rdy = sel ? req_ready_b : req_ready_a;
    while (!rdy && t < 100) begin
      @(posedge clk); #2;
      t++;
      rdy = sel ? req_ready_b : req_ready_a;
    end
    if (!rdy) chk("accept_timeout", {31'd0, rdy}, 32'd1);
    @(posedge clk); #2;
    acc = cyc;
    if (!sel) req_valid_a = 1'b0;
    else      req_valid_b = 1'b0;
    if (want_resp) begin
      e.rdata     = exp_rd;
      e.err       = exp_err;
      e.first_cyc = acc + (sel ? 1 : 4);
      if (!sel) q_a.push_back(e);
      else      q_b.push_back(e);
    end
  endtask

  task automatic wait_drain(input bit sel);
    int t = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    chk(sel ? "b_drain_timeout" : "a_drain_timeout",
        32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  task automatic chk_idle(input bit sel, input string nm);
    if (!sel) begin
      chk({nm, "_ready"}, {31'd0, req_ready_a}, 32'd1);
      chk({nm, "_busy"},  {31'd0, busy_a}, 32'd0);
      chk({nm, "_valid"}, {31'd0, resp_valid_a}, 32'd0);
    end else begin
      chk({nm, "_ready"}, {31'd0, req_ready_b}, 32'd1);
      chk({nm, "_busy"},  {31'd0, busy_b}, 32'd0);
      chk({nm, "_valid"}, {31'd0, resp_valid_b}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, k;
    rst_a = 1'b1; req_valid_a = 1'b0; req_write_a = 1'b0;
    req_addr_a = 32'd0; req_wdata_a = 32'd0; resp_ready_a = 1'b1;
    rst_b = 1'b1; req_valid_b = 1'b0; req_write_b = 1'b0;
    req_addr_b = 32'd0; req_wdata_b = 32'd0; resp_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state and 10 idle cycles
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk_idle(1'b0, "idle_a");
      @(posedge clk); #2;
    end
    chk_idle(1'b1, "idle_b");

    // Store 0xDEADBEEF to 0x10: busy through WAIT, valid at k+4, IDLE at k+5
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      chk("st_wait_busy", {31'd0, busy_a}, 32'd1);
      chk("st_wait_ready", {31'd0, req_ready_a}, 32'd0);
      chk("st_wait_valid", {31'd0, resp_valid_a}, 32'd0);
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    chk_idle(1'b0, "st_after");
    wait_drain(1'b0);

    // Load 0x10 with resp_ready low for 3 RESP cycles
    resp_ready_a = 1'b0;
    issue(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    k = 0;
    while (!resp_valid_a && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    repeat (3) begin
      @(posedge clk); #2;
    end
    resp_ready_a = 1'b1;
    @(posedge clk); #2;
    chk_idle(1'b0, "ld_after");
    wait_drain(1'b0);

    // Known value at word 0, then misaligned load and out-of-range store
    issue(1'b0, 1'b1, 32'h0, 32'h11111111, 32'd0, 1'b0, 1'b1, acc);
    wait_drain(1'b0);
    issue(1'b0, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 1'b1, acc);
    wait_drain(1'b0);
    issue(1'b0, 1'b1, 32'h400, 32'h55, 32'd0, 1'b1, 1'b1, acc);
    wait_drain(1'b0);
    issue(1'b0, 1'b0, 32'h0, 32'd0, 32'h11111111, 1'b0, 1'b1, acc);
    wait_drain(1'b0);

    // Reset lands on the WAIT->RESP edge of a store: nothing committed, no response
    issue(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1, acc);
    wait_drain(1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'h12345678, 32'd0, 1'b0, 1'b0, acc);
    while (cyc < acc + 3) begin
      @(posedge clk); #2;
    end
    rst_a = 1'b1;
    @(posedge clk); #2;
    rst_a = 1'b0;
    chk_idle(1'b0, "midrst");
    repeat (3) begin
      @(posedge clk); #2;
    end
    issue(1'b0, 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, acc);
    wait_drain(1'b0);

    // LATENCY=1: back-to-back store then load to 0x8, resp_ready held high
    issue(1'b1, 1'b1, 32'h8, 32'hA5A50001, 32'd0, 1'b0, 1'b1, acc1);
    issue(1'b1, 1'b0, 32'h8, 32'd0, 32'hA5A50001, 1'b0, 1'b1, acc2);
    chk("b_accept_gap", 32'(acc2 - acc1), 32'd3);
    wait_drain(1'b1);
    @(posedge clk); #2;
    chk_idle(1'b1, "b_after");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
